// File: rtl/rlsq_pkg.sv
// Shared definitions for reg_load_sequencer: state encoding and default widths.
package rlsq_pkg;

    localparam int WORD_SIZE_DEF      = 8;
    localparam int NUM_REGS_DEF       = 4;
    localparam int SEL_WIDTH_DEF      = 2;
    localparam int TIMEOUT_CYCLES_DEF = 15;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_REQ_ENC   = 2'd1;
    localparam logic [1:0] ST_WRITE_ENC = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_REQ   = ST_REQ_ENC,
        S_WRITE = ST_WRITE_ENC
    } state_t;

endpackage

// File: rtl/reg_load_sequencer_load_decoder.sv
// Registered one-hot decoder: one load strobe per destination register.
// An out-of-range destination index produces no strobe at all.
module load_decoder #(
    parameter int NUM_REGS  = 4,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [SEL_WIDTH-1:0] i_dest,
    output logic [NUM_REGS-1:0]  o_load
);

    logic [NUM_REGS-1:0] w_onehot;
    logic [NUM_REGS-1:0] r_load;

    // NOTE: default-assign every always_comb output first so no path leaves it unassigned (no latch).
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_en && (i_dest == SEL_WIDTH'(i))) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_load <= '0;
        end else begin
            r_load <= w_onehot;
        end
    end

    assign o_load = r_load;

endmodule

// File: rtl/reg_load_sequencer.sv
// Write-back sequencer: fetches one word via req/ack and strobes it into register R[dest].
// Optional REQ timeout abort is enabled by defining REG_LOAD_TIMEOUT_EN.
module reg_load_sequencer
    import rlsq_pkg::*;
#(
    parameter int WORD_SIZE      = WORD_SIZE_DEF,
    parameter int NUM_REGS       = NUM_REGS_DEF,
    parameter int SEL_WIDTH      = SEL_WIDTH_DEF
`ifdef REG_LOAD_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WORD_SIZE-1:0] i_addr,
    input  logic [SEL_WIDTH-1:0] i_dest,
    output logic                 o_mem_req,
    output logic [WORD_SIZE-1:0] o_mem_addr,
    input  logic                 i_mem_ack,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,
    output logic [WORD_SIZE-1:0] o_data_out,
    output logic [NUM_REGS-1:0]  o_load,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   w_accept;
    logic                   w_capture;
    logic                   w_timeout;

    logic                   r_mem_req;
    logic [WORD_SIZE-1:0]   r_mem_addr;
    logic [SEL_WIDTH-1:0]   r_dest;
    logic [WORD_SIZE-1:0]   r_data_out;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

`ifdef REG_LOAD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       r_cnt;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                // An ack on the final counted cycle still takes the normal path.
                if (i_mem_ack) begin
                    w_capture    = 1'b1;
                    w_next_state = S_WRITE;
                end
`ifdef REG_LOAD_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
`endif
            end
            S_WRITE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_dest     <= '0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mem_req <= (w_next_state == S_REQ);
            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= w_capture;
            r_err     <= w_timeout;
            if (w_accept) begin
                r_mem_addr <= i_addr;
                r_dest     <= i_dest;
            end
            if (w_capture) begin
                r_data_out <= i_mem_rdata;
            end
        end
    end

`ifdef REG_LOAD_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
`endif

    load_decoder #(
        .NUM_REGS  (NUM_REGS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_load_decoder (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_capture),
        .i_dest (r_dest),
        .o_load (o_load)
    );

    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;
    assign o_data_out = r_data_out;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Self-checking bench for reg_load_sequencer; expected write-backs go through a scoreboard queue.
// Define REG_LOAD_TIMEOUT_EN to exercise the timeout abort path.
module tb_reg_load_sequencer;

    logic       clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_addr;
    logic [1:0] i_dest;
    logic       o_mem_req;
    logic [7:0] o_mem_addr;
    logic       i_mem_ack;
    logic [7:0] i_mem_rdata;
    logic [7:0] o_data_out;
    logic [3:0] o_load;
    logic       o_busy;
    logic       o_done;
    logic       o_err;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] load;
    } exp_t;

    exp_t       sb[$];
    int         n_checks;
    int         n_pass;
    logic [7:0] last_data;

    reg_load_sequencer dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_addr      (i_addr),
        .i_dest      (i_dest),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_data_out  (o_data_out),
        .o_load      (o_load),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete load: start, wait_cycles REQ cycles without ack, then ack with rdata.
    task automatic run_op(input logic [7:0] addr, input logic [1:0] dest,
                          input logic [7:0] rdata, input int wait_cycles, input bit poke);
        int   lat;
        bit   ok;
        exp_t e;
        logic [3:0] exp_load;

        i_start = 1'b1;
        i_addr  = addr;
        i_dest  = dest;
        lat     = 0;
        tick;
        lat++;
        if (poke) begin
            i_start = 1'b1;
            i_addr  = 8'hEE;
            i_dest  = 2'd3;
        end else begin
            i_start = 1'b0;
            i_addr  = 8'($urandom);
            i_dest  = 2'($urandom);
        end

        n_checks++;
        if (o_mem_req !== 1'b1 || o_busy !== 1'b1 || o_mem_addr !== addr) begin
            $display("FAIL req_entry: got req=%b busy=%b addr=%h expected req=1 busy=1 addr=%h",
                     o_mem_req, o_busy, o_mem_addr, addr);
        end else n_pass++;

        ok = 1'b1;
        repeat (wait_cycles) begin
            tick;
            lat++;
            if (o_mem_req !== 1'b1 || o_mem_addr !== addr || o_data_out !== last_data ||
                o_load !== 4'b0000 || o_done !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL req_hold: got req=%b addr=%h data=%h expected req=1 addr=%h data=%h held",
                     o_mem_req, o_mem_addr, o_data_out, addr, last_data);
        end else n_pass++;

        exp_load = 4'b0001 << dest;
        i_mem_ack   = 1'b1;
        i_mem_rdata = rdata;
        sb.push_back('{data: rdata, load: exp_load});
        tick;
        lat++;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 8'($urandom);
        i_start     = 1'b0;

        while (o_done !== 1'b1 && lat < wait_cycles + 40) begin
            tick;
            lat++;
        end
        n_checks++;
        if (lat != wait_cycles + 2) begin
            $display("FAIL latency: got %0d cycles expected %0d", lat, wait_cycles + 2);
        end else n_pass++;

        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            if (o_data_out !== e.data || o_load !== e.load || o_done !== 1'b1 ||
                o_mem_req !== 1'b0 || o_busy !== 1'b1) begin
                $display("FAIL writeback: got data=%h load=%b done=%b req=%b busy=%b expected data=%h load=%b done=1 req=0 busy=1",
                         o_data_out, o_load, o_done, o_mem_req, o_busy, e.data, e.load);
            end else n_pass++;
        end
        last_data = rdata;

        tick;
        n_checks++;
        if (o_done !== 1'b0 || o_load !== 4'b0000 || o_busy !== 1'b0 || o_data_out !== rdata) begin
            $display("FAIL after_write: got done=%b load=%b busy=%b data=%h expected done=0 load=0000 busy=0 data=%h",
                     o_done, o_load, o_busy, o_data_out, rdata);
        end else n_pass++;
    endtask

    task automatic test_reset;
        i_rst       = 1'b0;
        i_start     = 1'b0;
        i_addr      = '0;
        i_dest      = '0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        last_data   = '0;
        tick;
        tick;
        n_checks++;
        if ({o_mem_req, o_busy, o_load, o_done, o_err} !== 8'h00) begin
            $display("FAIL reset_ctrl: got req=%b busy=%b load=%b done=%b err=%b expected all 0",
                     o_mem_req, o_busy, o_load, o_done, o_err);
        end else n_pass++;
        n_checks++;
        if (o_data_out !== 8'h00 || o_mem_addr !== 8'h00) begin
            $display("FAIL reset_data: got data=%h addr=%h expected 00 00", o_data_out, o_mem_addr);
        end else n_pass++;
        i_rst = 1'b1;
        tick;
        n_checks++;
        if (o_busy !== 1'b0 || o_mem_req !== 1'b0) begin
            $display("FAIL reset_release: got busy=%b req=%b expected 0 0", o_busy, o_mem_req);
        end else n_pass++;
    endtask

    task automatic test_basic;
        run_op(8'h10, 2'd2, 8'hA5, 2, 1'b0);
    endtask

    task automatic test_min_latency;
        run_op(8'h20, 2'd0, 8'h3C, 0, 1'b0);
        run_op(8'h31, 2'd1, 8'h96, 5, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_op(8'h40, 2'd1, 8'h5E, 3, 1'b1);
        run_op(8'h41, 2'd3, 8'hC7, 1, 1'b0);
    endtask

    task automatic test_ack_outside;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 8'hFF;
        tick;
        tick;
        n_checks++;
        if (o_data_out !== last_data || o_busy !== 1'b0 || o_done !== 1'b0 || o_load !== 4'b0000) begin
            $display("FAIL ack_idle: got data=%h busy=%b done=%b load=%b expected data=%h busy=0 done=0 load=0000",
                     o_data_out, o_busy, o_done, o_load, last_data);
        end else n_pass++;
        i_mem_ack = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid;
        bit ok;
        i_start = 1'b1;
        i_addr  = 8'h44;
        i_dest  = 2'd1;
        tick;
        i_start = 1'b0;
        tick;
        tick;
        #2;
        i_rst = 1'b0;
        #1;
        n_checks++;
        if ({o_mem_req, o_busy, o_load, o_done, o_err} !== 8'h00 || o_data_out !== 8'h00) begin
            $display("FAIL reset_mid: got req=%b busy=%b load=%b data=%h expected all 0",
                     o_mem_req, o_busy, o_load, o_data_out);
        end else n_pass++;
        last_data = 8'h00;
        tick;
        tick;
        i_rst       = 1'b1;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 8'h99;
        ok = 1'b1;
        repeat (5) begin
            tick;
            if (o_load !== 4'b0000 || o_done !== 1'b0 || o_busy !== 1'b0 || o_data_out !== 8'h00) ok = 1'b0;
        end
        i_mem_ack = 1'b0;
        n_checks++;
        if (!ok) begin
            $display("FAIL reset_no_load: got load=%b done=%b busy=%b data=%h expected 0000 0 0 00",
                     o_load, o_done, o_busy, o_data_out);
        end else n_pass++;
    endtask

    task automatic test_timeout;
        bit ok;
        int cnt;
        exp_t e;
        i_start = 1'b1;
        i_addr  = 8'h77;
        i_dest  = 2'd2;
        tick;
        i_start = 1'b0;
        cnt = 1;
        ok  = 1'b1;
`ifdef REG_LOAD_TIMEOUT_EN
        while (o_err !== 1'b1 && cnt < 40) begin
            if (o_load !== 4'b0000 || o_done !== 1'b0) ok = 1'b0;
            tick;
            cnt++;
        end
        n_checks++;
        if (cnt != 16 || !ok) begin
            $display("FAIL timeout_err: got err at cycle %0d ok=%b expected cycle 16 ok=1", cnt, ok);
        end else n_pass++;
        n_checks++;
        if (o_busy !== 1'b0 || o_mem_req !== 1'b0 || o_load !== 4'b0000 || o_done !== 1'b0) begin
            $display("FAIL timeout_state: got busy=%b req=%b load=%b done=%b expected 0 0 0000 0",
                     o_busy, o_mem_req, o_load, o_done);
        end else n_pass++;
        tick;
        n_checks++;
        if (o_err !== 1'b0 || o_data_out !== last_data) begin
            $display("FAIL timeout_pulse: got err=%b data=%h expected err=0 data=%h", o_err, o_data_out, last_data);
        end else n_pass++;
        run_op(8'h78, 2'd0, 8'h6B, 14, 1'b0);
`else
        repeat (110) begin
            if (o_mem_req !== 1'b1 || o_err !== 1'b0 || o_busy !== 1'b1 || o_load !== 4'b0000) ok = 1'b0;
            tick;
            cnt++;
        end
        n_checks++;
        if (!ok) begin
            $display("FAIL no_timeout_hold: got req=%b err=%b busy=%b expected 1 0 1 for 110 cycles",
                     o_mem_req, o_err, o_busy);
        end else n_pass++;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 8'h5A;
        sb.push_back('{data: 8'h5A, load: 4'b0100});
        tick;
        i_mem_ack = 1'b0;
        n_checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            if (o_done !== 1'b1 || o_load !== e.load || o_data_out !== e.data || o_err !== 1'b0) begin
                $display("FAIL late_ack: got done=%b load=%b data=%h err=%b expected 1 %b %h 0",
                         o_done, o_load, o_data_out, o_err, e.load, e.data);
            end else n_pass++;
        end
        last_data = 8'h5A;
        tick;
        n_checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            $display("FAIL late_ack_idle: got busy=%b done=%b expected 0 0", o_busy, o_done);
        end else n_pass++;
`endif
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset;
        test_basic;
        test_min_latency;
        test_back_to_back;
        test_ack_outside;
        test_reset_mid;
        test_timeout;
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
